bin2bcd_4digit: RTL and testbench
=================================

// Module: bin2bcd_4digit
// PURPOSE
//   Sequential double-dabble converter: binary value -> four BCD digits (thousand..digit).
//   Sits directly upstream of the 4-digit multiplexed 7-segment driver and feeds its four BCD inputs.
//   One conversion per start request; outputs are held stable between conversions so the display never flickers.
// PARAMETERS
//   IN_W     14     width of binary input (2^14-1 = 16383 covers 0..9999 plus overflow range)
//   MAX_VAL  9999   largest displayable value; larger inputs saturate
// PORTS
//   clk        in   1     system clock (50 MHz); single clock domain
//   rst        in   1     synchronous, active-high reset
//   bin_in     in   IN_W  binary value; sampled only on accepted start
//   start      in   1     conversion request; accepted only when busy=0
//   busy       out  1     high while conversion in progress
//   done       out  1     one-cycle pulse; BCD outputs updated in same cycle
//   overflow   out  1     registered; 1 if last accepted bin_in > MAX_VAL
//   digit      out  4     BCD units (rightmost)
//   ten        out  4     BCD tens
//   hundred    out  4     BCD hundreds
//   thousand   out  4     BCD thousands (leftmost)
// BEHAVIOUR
//   - Reset (rst=1 at posedge clk): state=IDLE; busy=0, done=0, overflow=0, all digits=4'd0.
//   - States: IDLE -> SHIFT -> LOAD -> IDLE.
//     IDLE : start=1 -> latch bin_in into shift reg, clear 16-bit BCD scratch, bit counter=IN_W-1, go SHIFT.
//            busy=1 from the cycle after start is sampled.
//     SHIFT: each cycle, for each BCD nibble >= 5 add 3, then shift {bcd,bin} left 1. Exactly IN_W cycles;
//            counter decrements; at counter=0 go LOAD.
//     LOAD : copy scratch to digit/ten/hundred/thousand, pulse done=1, busy=0, go IDLE.
//   - Latency: start sampled at edge N -> done=1 and new digits visible after edge N+IN_W+1 (IN_W+1 cycles).
//   - Saturation: if latched value > MAX_VAL, LOAD writes 9,9,9,9 and overflow=1; otherwise overflow=0.
//     Comparison on the latched value, not live bin_in.
//   - Output hold: digit outputs change only in LOAD or reset; during SHIFT they keep the previous result.
//   - start while busy=1 (SHIFT or LOAD): ignored, not queued. start in the same cycle as done=1 (LOAD):
//     ignored; accepted in the next IDLE cycle.
//   - bin_in changes after acceptance: no effect on the running conversion.
//   - rst during SHIFT/LOAD: aborts immediately, reset values as above, no done pulse.
//   - Scratch width 16 bits (4 nibbles); nibble correction must not carry into the next nibble within a cycle.
//   - done is never asserted for two consecutive cycles.
// CONFIGURATION
//   LEADING_BLANK_EN defined: in LOAD, leading zero digits (thousand, then hundred, then ten) are replaced
//     by 4'hF so the downstream encoder blanks them; digit (units) always shows a numeral (0 -> "   0").
//     Blanking stops at the first non-zero digit (1005 -> 1,0,0,5; 40 -> F,F,4,0). Saturated output 9999 unaffected.
//   LEADING_BLANK_EN undefined: all four digits are always 0..9; leading zeros displayed.
// TESTING
//   1. rst=1 two cycles -> busy=0, done=0, overflow=0, digits 0,0,0,0.
//   2. bin_in=1234, start one cycle -> busy=1 for IN_W cycles, done exactly 15 cycles after start edge, digits 1,2,3,4.
//   3. bin_in=9999 then bin_in=0 -> 9,9,9,9 overflow=0; then 0,0,0,0 (blank build: F,F,F,0).
//   4. bin_in=12000 -> digits 9,9,9,9, overflow=1; next bin_in=7 -> overflow=0, 0,0,0,7 (blank: F,F,F,7).
//   5. start=1 held continuously with bin_in=42 -> done pulses every IN_W+2 cycles, never back-to-back; change bin_in to 99 mid-SHIFT -> current result still 42.
//   6. rst asserted 5 cycles into conversion of 5678 -> no done pulse, digits 0,0,0,0; fresh start -> 5,6,7,8.

Source files
------------

// File: rtl/bin2bcd_4digit.sv
// Sequential double-dabble binary -> 4-digit BCD converter with saturation at MAX_VAL.
// Optional leading-zero blanking is enabled by defining LEADING_BLANK_EN.
module bin2bcd_4digit #(
    parameter int IN_W    = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] bin_in,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic [3:0]      digit,
    output logic [3:0]      ten,
    output logic [3:0]      hundred,
    output logic [3:0]      thousand
);

    localparam int CNT_W = $clog2(IN_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t           state_q;
    logic [IN_W-1:0]  bin_q;
    logic [IN_W-1:0]  bin_d;
    logic [15:0]      bcd_q;
    logic [15:0]      bcd_d;
    logic [15:0]      adj_d;
    logic [15:0]      load_d;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic [15:0]      digits_q;
    logic             blank3_d;
    logic             blank2_d;
    logic             blank1_d;

    // Each nibble is corrected in 4 bits so no carry can leak into its neighbour.
    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    // Next scratch value: correct every nibble, then shift {bcd,bin} left by one.
    always_comb begin
        adj_d = {dabble(bcd_q[15:12]), dabble(bcd_q[11:8]),
                 dabble(bcd_q[7:4]),   dabble(bcd_q[3:0])};
        bcd_d = {adj_d[14:0], bin_q[IN_W-1]};
        bin_d = {bin_q[IN_W-2:0], 1'b0};
    end

    // Value written to the display registers in LOAD (saturation, optional blanking).
    always_comb begin
        load_d   = sat_q ? 16'h9999 : bcd_q;
`ifdef LEADING_BLANK_EN
        blank3_d = (load_d[15:12] == 4'd0);
        blank2_d = blank3_d && (load_d[11:8] == 4'd0);
        blank1_d = blank2_d && (load_d[7:4] == 4'd0);
`else
        blank3_d = 1'b0;
        blank2_d = 1'b0;
        blank1_d = 1'b0;
`endif
        load_d[15:12] = blank3_d ? 4'hF : load_d[15:12];
        load_d[11:8]  = blank2_d ? 4'hF : load_d[11:8];
        load_d[7:4]   = blank1_d ? 4'hF : load_d[7:4];
    end

    // Conversion FSM with registered handshake and display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            bcd_q    <= 16'h0000;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            digits_q <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        bin_q   <= bin_in;
                        bcd_q   <= 16'h0000;
                        cnt_q   <= CNT_W'(IN_W - 1);
                        sat_q   <= (bin_in > IN_W'(MAX_VAL));
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    done_q <= 1'b0;
                    bin_q  <= bin_d;
                    bcd_q  <= bcd_d;
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= LOAD;
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                        state_q <= SHIFT;
                    end
                end
                LOAD: begin
                    digits_q <= load_d;
                    ovf_q    <= sat_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign thousand = digits_q[15:12];
    assign hundred  = digits_q[11:8];
    assign ten      = digits_q[7:4];
    assign digit    = digits_q[3:0];

endmodule

// File: tb/tb_bin2bcd_4digit.sv
// Self-checking bench for bin2bcd_4digit: vector table, random values against an
// arithmetic reference model, and hand-written handshake/reset sequences.
module tb_bin2bcd_4digit;

`ifdef LEADING_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] bin_in = 14'd0;
    logic        start = 1'b0;
    logic        busy, done, overflow;
    logic [3:0]  digit, ten, hundred, thousand;

    int n_tests = 0;
    int n_fail  = 0;

    bin2bcd_4digit #(.IN_W(14), .MAX_VAL(9999)) dut (
        .clk(clk), .rst(rst), .bin_in(bin_in), .start(start),
        .busy(busy), .done(done), .overflow(overflow),
        .digit(digit), .ten(ten), .hundred(hundred), .thousand(thousand)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] val;
        logic [15:0] exp_plain;
        logic [15:0] exp_blank;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl[10];

    // Reference: decimal digits by division, saturation and blanking from the value itself.
    function automatic logic [16:0] model(input int v);
        int d3, d2, d1, d0;
        if (v > 9999) return {1'b1, 16'h9999};
        d3 = v / 1000;
        d2 = (v / 100) % 10;
        d1 = (v / 10) % 10;
        d0 = v % 10;
        if (BLANK && v < 1000) d3 = 15;
        if (BLANK && v < 100)  d2 = 15;
        if (BLANK && v < 10)   d1 = 15;
        return {1'b0, d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {thousand, hundred, ten, digit};
    endfunction

    // One conversion: start pulse, bounded wait for done, plus ignored start and bin_in noise mid-run.
    task automatic run_conv(input logic [13:0] v, output logic [15:0] res, output logic ovf,
                            output int lat, output int busy_cnt, output bit hold_bad, output bit dbl);
        logic [15:0] prev;
        @(negedge clk);
        prev   = outs();
        bin_in = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        bin_in   = 14'($urandom);
        lat      = 0;
        busy_cnt = 0;
        hold_bad = 1'b0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (outs() !== prev) hold_bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
            if (lat == 5) begin
                start  = 1'b1;
                bin_in = 14'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        res = outs();
        ovf = overflow;
        @(posedge clk);
        #1;
        dbl = done;
    endtask

    initial begin
        logic [15:0] res;
        logic        ovf;
        int          lat, bcnt, nd;
        bit          hold_bad, dbl, b2b, prev_done, seen;
        logic [16:0] m;
        int          t[4];
        logic [15:0] r[4];

        tbl[0] = '{14'd1234,  16'h1234, 16'h1234, 1'b0};
        tbl[1] = '{14'd9999,  16'h9999, 16'h9999, 1'b0};
        tbl[2] = '{14'd0,     16'h0000, 16'hFFF0, 1'b0};
        tbl[3] = '{14'd12000, 16'h9999, 16'h9999, 1'b1};
        tbl[4] = '{14'd7,     16'h0007, 16'hFFF7, 1'b0};
        tbl[5] = '{14'd10000, 16'h9999, 16'h9999, 1'b1};
        tbl[6] = '{14'd16383, 16'h9999, 16'h9999, 1'b1};
        tbl[7] = '{14'd1005,  16'h1005, 16'h1005, 1'b0};
        tbl[8] = '{14'd40,    16'h0040, 16'hFF40, 1'b0};
        tbl[9] = '{14'd100,   16'h0100, 16'hF100, 1'b0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_ovf", {31'd0, overflow}, 32'd0);
        check("reset_digits", {16'd0, outs()}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_conv(tbl[i].val, res, ovf, lat, bcnt, hold_bad, dbl);
            check($sformatf("vec%0d_digits", i), {16'd0, res},
                  {16'd0, (BLANK ? tbl[i].exp_blank : tbl[i].exp_plain)});
            check($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, tbl[i].exp_ovf});
            check($sformatf("vec%0d_latency", i), lat, 32'd15);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, 32'd14);
            check($sformatf("vec%0d_hold", i), {31'd0, hold_bad}, 32'd0);
            check($sformatf("vec%0d_done_single", i), {31'd0, dbl}, 32'd0);
        end

        for (int i = 0; i < 30; i++) begin
            int v;
            v = ($urandom % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 16383));
            m = model(v);
            run_conv(14'(v), res, ovf, lat, bcnt, hold_bad, dbl);
            check($sformatf("rand_%0d_digits", v), {16'd0, res}, {16'd0, m[15:0]});
            check($sformatf("rand_%0d_ovf", v), {31'd0, ovf}, {31'd0, m[16]});
            check($sformatf("rand_%0d_latency", v), lat, 32'd15);
        end

        // start held high: back-to-back conversions, bin_in changed mid-SHIFT of the second one.
        @(negedge clk);
        bin_in    = 14'd42;
        start     = 1'b1;
        nd        = 0;
        b2b       = 1'b0;
        prev_done = 1'b0;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk);
            #1;
            if (c == 20) bin_in = 14'd99;
            if (done) begin
                if (prev_done) b2b = 1'b1;
                if (nd < 4) begin
                    t[nd] = c;
                    r[nd] = outs();
                end
                nd++;
            end
            prev_done = done;
        end
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = done;
        end
        check("hold_start_done_count", nd, 32'd4);
        check("hold_start_back_to_back", {31'd0, b2b}, 32'd0);
        check("hold_start_drain", {31'd0, seen}, 32'd1);
        if (nd >= 4) begin
            check("hold_start_first_done", t[0], 32'd15);
            check("hold_start_period1", t[1] - t[0], 32'd16);
            check("hold_start_period3", t[3] - t[2], 32'd16);
            m = model(42);
            check("hold_start_r0", {16'd0, r[0]}, {16'd0, m[15:0]});
            check("hold_start_r1_still42", {16'd0, r[1]}, {16'd0, m[15:0]});
            m = model(99);
            check("hold_start_r2", {16'd0, r[2]}, {16'd0, m[15:0]});
            check("hold_start_r3", {16'd0, r[3]}, {16'd0, m[15:0]});
        end
        @(posedge clk);

        run_conv(14'd12000, res, ovf, lat, bcnt, hold_bad, dbl);
        check("pre_abort_ovf", {31'd0, ovf}, 32'd1);

        // Reset five cycles into a conversion: abort without a done pulse.
        @(negedge clk);
        bin_in = 14'd5678;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("abort_no_done", {31'd0, seen}, 32'd0);
        check("abort_digits", {16'd0, outs()}, 32'd0);
        check("abort_ovf", {31'd0, overflow}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);

        run_conv(14'd5678, res, ovf, lat, bcnt, hold_bad, dbl);
        check("after_abort_digits", {16'd0, res}, 32'h5678);
        check("after_abort_latency", lat, 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
